ysyx_22050133_ifetch_responder: RTL and testbench
=================================================

// Module: ysyx_22050133_ifetch_responder
// PURPOSE
//  Instruction-memory responder: the slave end of the IFU fetch handshake.
//  - Accepts a PC request (pc_valid_i/pc_ready_o) and reads a local 64-bit-wide array after LATENCY cycles.
//  - Returns inst64_o with inst64_o[31:0] holding the addressed instruction.
//  - Sits between the IFU and the simulated instruction store; supports flush cancellation and a preload port.
// PARAMETERS
//  BASE     64'h8000_0000  byte address of array word 0 (reset PC)
//  DEPTH    4096           array depth in 64-bit dwords (power of 2)
//  LATENCY  2              cycles from request acceptance to response valid (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous assert, active-low (0 = reset)
//  pc_valid_i   in   1   IFU presents a fetch PC
//  pc_i         in   64  fetch byte address
//  pc_ready_o   out  1   responder can accept a request this cycle
//  flush_i      in   1   cancel any in-flight/held response
//  inst_valid_o out  1   inst64_o/err_o are valid (held until next accept/flush)
//  inst64_o     out  64  {32'b0, insn} if pc_i[2]=1 else raw dword (insn in [31:0])
//  err_o        out  1   misaligned (pc_i[1:0]!=0) or out-of-range fetch
//  ld_en_i      in   1   preload write enable
//  ld_addr_i    in   log2(DEPTH)  preload dword index
//  ld_data_i    in   64  preload data
//  rsp_cnt_o    out  32  responses delivered, wraps at 2^32
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE; inst_valid_o=0, inst64_o=0, err_o=0, rsp_cnt_o=0.
//  - pc_ready_o=1 (decoded from state); array contents are not reset.
//  FSM states: IDLE, BUSY, DONE.
//  - pc_ready_o=1 in IDLE and DONE, 0 in BUSY.
//  - Accept = pc_valid_i & pc_ready_o:
//    - latch pc_i; cnt<=LATENCY-1; state<=BUSY; inst_valid_o<=0.
//  - BUSY, cnt!=0: cnt<=cnt-1.
//  - BUSY, cnt==0: perform read; load inst64_o/err_o; inst_valid_o<=1; rsp_cnt_o+=1; state<=DONE.
//  - Timing: accept at edge N -> inst_valid_o=1 after edge N+LATENCY.
//    LATENCY=1 gives valid the cycle after accept.
//  - DONE: hold inst64_o, err_o and inst_valid_o=1 indefinitely (no response ready).
//    - A new accept drops inst_valid_o at the next edge.
//  Address mapping:
//  - idx = (pc - BASE) >> 3, truncated to log2(DEPTH) bits.
//  - Out of range: pc < BASE or pc >= BASE + 8*DEPTH, 64-bit unsigned compare.
//  - Error (misaligned or out of range): inst64_o=0, err_o=1, still a normal response (counted).
//  - Otherwise err_o=0; word select by latched pc[2].
//  flush_i (highest priority on state):
//  - BUSY or DONE -> IDLE, inst_valid_o<=0, pending read discarded, not counted.
//  - If pc_valid_i is also high that cycle, the new request is accepted instead (->BUSY);
//    this is the redirect case and the old request is still discarded.
//  - flush_i in IDLE with no request: no effect.
//  Preload:
//  - ld_en_i writes array[ld_addr_i] at posedge in any state.
//  - If the write hits the dword read in the same cycle (BUSY, cnt==0), the read returns ld_data_i (write-first).
//  Reset mid-operation: async clear to IDLE; the in-flight request is lost and no response is produced.
//  inst64_o only changes on a response load or reset; flush does not zero it.
// TESTING
//  1. Reset release, preload idx0=64'h1111_2222_3333_4444, LATENCY=2, req pc=8000_0000 at edge N
//     -> pc_ready_o=0 for 2 cycles; valid after N+2; inst64_o=64'h1111_2222_3333_4444; rsp_cnt_o=1.
//  2. Req pc=8000_0004, same data -> inst64_o=64'h0000_0000_1111_2222, err_o=0.
//  3. Req pc=8000_0002, then pc=7FFF_FFF8, then pc=BASE+8*DEPTH
//     -> each response inst64_o=0, err_o=1, inst_valid_o=1; rsp_cnt_o increments by 3.
//  4. Accept, then flush_i one cycle later with pc_valid_i=0
//     -> no inst_valid_o pulse; pc_ready_o=1 next cycle; rsp_cnt_o unchanged.
//  5. DONE holding A; flush_i+pc_valid_i with pc=B in the same cycle
//     -> inst_valid_o=0 next cycle; B's data valid LATENCY cycles after accept; A never re-presented.
//  6. Write idx k via ld_en_i in the read cycle of pc=BASE+8k -> new data returned.
//     Assert rst=0 during BUSY -> all outputs 0 immediately, pc_ready_o=1.

Source files
------------

// File: rtl/ysyx_22050133_ifetch_responder.sv
// Instruction-memory responder for the IFU fetch handshake.
// It accepts one fetch PC at a time and answers LATENCY cycles later from a
// local dword array. The answer stays on the outputs until the next accept or
// flush. A preload port writes the array in any state, and the write is
// forwarded into a read of the same dword in the same cycle.
module ysyx_22050133_ifetch_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_valid_i,
  input  logic [63:0]              pc_i,
  output logic                     pc_ready_o,
  input  logic                     flush_i,
  output logic                     inst_valid_o,
  output logic [63:0]              inst64_o,
  output logic                     err_o,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [63:0]              ld_data_i,
  output logic [31:0]              rsp_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  // The countdown starts at LATENCY-1, so $clog2(LATENCY) bits are enough.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  // Byte span covered by the array, measured from BASE.
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [63:0]    pc_lat;
  logic [CW-1:0]  cnt;
  logic [63:0]    mem [DEPTH];

  logic           accept;
  logic           read_now;
  logic [63:0]    offset;
  logic [AW-1:0]  idx;
  logic           misaligned;
  logic           out_of_range;
  logic [63:0]    raw_word;
  logic [63:0]    word;
  logic [63:0]    rsp_data;
  logic           rsp_err;

  // The ready output depends only on the state, so it has no
  // combinational path from the request inputs.
  assign pc_ready_o = (state != BUSY);

  // A flush that arrives with a request redirects the fetch. The new PC is
  // taken even while BUSY, and the old request is dropped.
  assign accept   = pc_valid_i & (pc_ready_o | flush_i);
  assign read_now = (state == BUSY) && (cnt == '0);

  // Address decode of the latched PC.
  // The offset is exact when pc >= BASE, so the range check can use it.
  assign offset       = pc_lat - BASE;
  assign idx          = offset[AW+2:3];
  assign misaligned   = (pc_lat[1:0] != 2'b00);
  assign out_of_range = (pc_lat < BASE) || (offset >= SPAN);

  // Next-state logic. Accept has priority, then flush, then the countdown.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          state_next = BUSY;
        end else if (flush_i) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = BUSY;
        end else if (flush_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset abandons any in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Array read with write-first forwarding from the preload port.
  always_comb begin
    raw_word = mem[idx];
    word     = raw_word;
    if (ld_en_i && (ld_addr_i == idx)) begin
      word = ld_data_i;
    end
  end

  // Response formatting. The upper word of a dword is moved down to [31:0].
  // Errors return zero data.
  always_comb begin
    rsp_data = 64'd0;
    rsp_err  = 1'b0;
    if (misaligned || out_of_range) begin
      rsp_err = 1'b1;
    end else if (pc_lat[2]) begin
      rsp_data = {32'd0, word[63:32]};
    end else begin
      rsp_data = word;
    end
  end

  // Request latch, countdown and response registers.
  // A flush clears the valid flag but leaves the data in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_lat       <= 64'd0;
      cnt          <= '0;
      inst_valid_o <= 1'b0;
      inst64_o     <= 64'd0;
      err_o        <= 1'b0;
      rsp_cnt_o    <= 32'd0;
    end else if (accept) begin
      pc_lat       <= pc_i;
      cnt          <= CNT_INIT;
      inst_valid_o <= 1'b0;
    end else if (flush_i) begin
      inst_valid_o <= 1'b0;
    end else if (read_now) begin
      inst64_o     <= rsp_data;
      err_o        <= rsp_err;
      inst_valid_o <= 1'b1;
      rsp_cnt_o    <= rsp_cnt_o + 32'd1;
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Preload port into the instruction store. The array contents are not reset.
  always_ff @(posedge clk) begin
    if (ld_en_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_ifetch_responder.sv
// Self-checking bench for the fetch responder.
// A transaction-level model tracks the pending fetch by its due cycle and
// checks every DUT output on each cycle. Literal checks pin the key values.
module tb_ysyx_22050133_ifetch_responder;

  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int          DEPTH   = 4096;
  localparam int          LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [63:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        inst_valid;
  logic [63:0] inst64;
  logic        err;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [63:0] ld_data;
  logic [31:0] rsp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the array image, one pending fetch, and the held response.
  logic [63:0] mmem [0:DEPTH-1];
  bit          m_pend  = 1'b0;
  logic [63:0] m_pc    = 64'd0;
  int          m_due   = 0;
  int          cyc     = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_data  = 64'd0;
  bit          m_err   = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  always #5 clk = ~clk;

  ysyx_22050133_ifetch_responder #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_valid_i  (pc_valid),
    .pc_i        (pc),
    .pc_ready_o  (pc_ready),
    .flush_i     (flush),
    .inst_valid_o(inst_valid),
    .inst64_o    (inst64),
    .err_o       (err),
    .ld_en_i     (ld_en),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data),
    .rsp_cnt_o   (rsp_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_data  = 64'd0;
    m_err   = 1'b0;
    m_cnt   = 32'd0;
  endtask

  // The answer for a PC, taken directly from the address rules.
  task automatic model_resolve();
    logic [63:0] w;
    int          i;
    if (m_pc[1:0] != 2'b00 || m_pc < BASE || m_pc >= BASE + 64'(DEPTH) * 64'd8) begin
      m_data = 64'd0;
      m_err  = 1'b1;
    end else begin
      i      = int'((m_pc - BASE) >> 3);
      w      = mmem[i];
      m_data = m_pc[2] ? {32'd0, w[63:32]} : w;
      m_err  = 1'b0;
    end
  endtask

  // Advance the model by one rising edge, using the inputs held across it.
  task automatic model_step();
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      // The write happens before the read, so a read at this edge sees the new data.
      if (ld_en) mmem[ld_addr] = ld_data;
      if (pc_valid && (!m_pend || flush)) begin
        m_pend  = 1'b1;
        m_pc    = pc;
        m_due   = cyc + LATENCY;
        m_valid = 1'b0;
      end else if (flush) begin
        m_pend  = 1'b0;
        m_valid = 1'b0;
      end else if (m_pend && cyc == m_due) begin
        model_resolve();
        m_pend  = 1'b0;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc_ready",   64'(pc_ready),   64'(!m_pend));
    chk("inst_valid", 64'(inst_valid), 64'(m_valid));
    chk("err",        64'(err),        64'(m_err));
    chk("inst64",     inst64,          m_data);
    chk("rsp_cnt",    64'(rsp_cnt),    64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Drive one request for one cycle, then wait out the latency.
  task automatic request(input logic [63:0] addr);
    pc_valid = 1'b1;
    pc       = addr;
    tick();
    pc_valid = 1'b0;
    repeat (LATENCY) tick();
    $display("txn pc=%h valid=%b inst=%h err=%b cnt=%0d", addr, inst_valid, inst64, err, rsp_cnt);
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    $display("txn preload idx=%0d data=%h", a, d);
  endtask

  logic [63:0] seq_pcs [4];

  initial begin
    rst      = 1'b0;
    pc_valid = 1'b0;
    pc       = 64'd0;
    flush    = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = 12'd0;
    ld_data  = 64'd0;
    tick();
    tick();
    chk("reset_ready", 64'(pc_ready), 64'd1);
    chk("reset_valid", 64'(inst_valid), 64'd0);
    chk("reset_cnt", 64'(rsp_cnt), 64'd0);
    chk("reset_inst", inst64, 64'd0);
    rst = 1'b1;
    tick();

    preload(12'd0, 64'h1111_2222_3333_4444);
    preload(12'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    preload(12'd7, 64'h7777_0000_7777_0001);
    preload(12'd4095, 64'hFEDC_BA98_7654_3210);

    // Test 1: basic fetch with exact timing.
    pc_valid = 1'b1;
    pc       = 64'h8000_0000;
    tick();
    pc_valid = 1'b0;
    chk("t1_busy_ready0", 64'(pc_ready), 64'd0);
    tick();
    chk("t1_busy_ready1", 64'(pc_ready), 64'd0);
    chk("t1_not_yet_valid", 64'(inst_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(inst_valid), 64'd1);
    chk("t1_inst", inst64, 64'h1111_2222_3333_4444);
    chk("t1_cnt", 64'(rsp_cnt), 64'd1);
    $display("txn pc=%h valid=%b inst=%h err=%b cnt=%0d", 64'h8000_0000, inst_valid, inst64, err, rsp_cnt);
    tick();
    chk("t1_hold", 64'(inst_valid), 64'd1);

    // Test 2: upper-word select.
    request(64'h8000_0004);
    chk("t2_inst", inst64, 64'h0000_0000_1111_2222);
    chk("t2_err", 64'(err), 64'd0);

    // Test 3: error responses, then the last in-range dword.
    request(64'h8000_0002);
    request(64'h7FFF_FFF8);
    request(64'h8000_8000);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_inst", inst64, 64'd0);
    chk("t3_cnt", 64'(rsp_cnt), 64'd5);
    request(64'h8000_7FFC);
    chk("t3_top_inst", inst64, 64'h0000_0000_FEDC_BA98);

    // Test 4: flush cancels an in-flight fetch.
    pc_valid = 1'b1;
    pc       = 64'h8000_0008;
    tick();
    pc_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    chk("t4_ready", 64'(pc_ready), 64'd1);
    repeat (3) tick();
    chk("t4_no_valid", 64'(inst_valid), 64'd0);
    chk("t4_cnt", 64'(rsp_cnt), 64'd6);
    $display("txn flushed pc=%h cnt=%0d", 64'h8000_0008, rsp_cnt);

    // Test 5: redirect while a response is held in DONE.
    request(64'h8000_0000);
    flush    = 1'b1;
    pc_valid = 1'b1;
    pc       = 64'h8000_0008;
    tick();
    flush    = 1'b0;
    pc_valid = 1'b0;
    chk("t5_drop", 64'(inst_valid), 64'd0);
    tick();
    chk("t5_wait", 64'(inst_valid), 64'd0);
    tick();
    chk("t5_valid", 64'(inst_valid), 64'd1);
    chk("t5_inst", inst64, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t5_cnt", 64'(rsp_cnt), 64'd8);
    $display("txn redirect pc=%h inst=%h cnt=%0d", 64'h8000_0008, inst64, rsp_cnt);

    // Redirect while BUSY: only the new PC is answered.
    pc_valid = 1'b1;
    pc       = 64'h8000_0004;
    tick();
    flush    = 1'b1;
    pc       = 64'h8000_000C;
    tick();
    flush    = 1'b0;
    pc_valid = 1'b0;
    repeat (LATENCY) tick();
    chk("busy_redirect_inst", inst64, 64'h0000_0000_AAAA_BBBB);
    chk("busy_redirect_cnt", 64'(rsp_cnt), 64'd9);
    $display("txn busy-redirect pc=%h inst=%h cnt=%0d", 64'h8000_000C, inst64, rsp_cnt);

    // Back-to-back requests with pc_valid held high. The model does the checking.
    seq_pcs[0] = 64'h8000_0000;
    seq_pcs[1] = 64'h8000_000C;
    seq_pcs[2] = 64'h8000_0001;
    seq_pcs[3] = 64'h8000_003C;
    pc_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pc = seq_pcs[i % 4];
      tick();
    end
    pc_valid = 1'b0;
    repeat (LATENCY + 1) tick();
    $display("txn back-to-back burst done cnt=%0d", rsp_cnt);

    // Test 6: a preload write in the read cycle is forwarded (write-first).
    pc_valid = 1'b1;
    pc       = 64'h8000_0038;
    tick();
    pc_valid = 1'b0;
    tick();
    ld_en   = 1'b1;
    ld_addr = 12'd7;
    ld_data = 64'h9999_8888_7777_6666;
    tick();
    ld_en   = 1'b0;
    chk("t6_write_first", inst64, 64'h9999_8888_7777_6666);
    $display("txn write-first pc=%h inst=%h", 64'h8000_0038, inst64);

    // A write to another dword in the read cycle leaves the read unchanged.
    pc_valid = 1'b1;
    pc       = 64'h8000_0000;
    tick();
    pc_valid = 1'b0;
    tick();
    ld_en   = 1'b1;
    ld_addr = 12'd2;
    ld_data = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    ld_en   = 1'b0;
    chk("t6_other_write", inst64, 64'h1111_2222_3333_4444);
    $display("txn side-write pc=%h inst=%h", 64'h8000_0000, inst64);

    // An asynchronous reset while BUSY clears the outputs at once.
    pc_valid = 1'b1;
    pc       = 64'h8000_0008;
    tick();
    pc_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("arst_ready", 64'(pc_ready), 64'd1);
    chk("arst_valid", 64'(inst_valid), 64'd0);
    chk("arst_inst", inst64, 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_cnt", 64'(rsp_cnt), 64'd0);
    $display("txn async reset during busy");
    tick();
    tick();
    rst = 1'b1;
    tick();
    request(64'h8000_0000);
    chk("post_reset_inst", inst64, 64'h1111_2222_3333_4444);
    chk("post_reset_cnt", 64'(rsp_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
